// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encodings, word geometry
// and the latched request record.
// Optional feature macro: MEM_ALIGN_CHECK_EN (see mem_responder.sv).
package mem_responder_pkg;

    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;
    localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

    // FSM encodings, kept as plain 2-bit constants for legacy compatibility
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // One request as captured at acceptance
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle control path (master) and
// the memory responder (slave).
// Optional feature macro: MEM_ALIGN_CHECK_EN adds resp_err.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; we/addr/wdata are sampled on that edge only.
// req_ready is high only while the responder is idle, and a request shown
// while req_ready is low is ignored rather than queued. The response is a
// single-cycle resp_valid pulse with no back-pressure; resp_rdata (and
// resp_err) are meaningful only while resp_valid is high.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic              resp_err;
`endif

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
`ifdef MEM_ALIGN_CHECK_EN
        , input resp_err
`endif
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
`ifdef MEM_ALIGN_CHECK_EN
        , output resp_err
`endif
    );

endinterface

// File: rtl/mem_word_array.sv
// DEPTH_WORDS x 32 word store: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module mem_word_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Write port: commit one word on the clock edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the IorD address path. Accepts one word
// request, waits LATENCY cycles in BUSY, then pulses resp_valid for one
// cycle in RESP. Reads and writes both take effect on the edge that enters
// RESP, so a reset during BUSY drops the request with no side effect.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- rejects accesses whose byte
// offset is non-zero (resp_err=1, no write, zero data). Without it the byte
// offset is ignored and the containing word is accessed.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic [1:0]      dbg_state
);

    localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    req_t              lat;
    req_t              cur;
    logic              accept;
    logic              enter_resp;
    logic              bad_align;
    logic              arr_we;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] arr_rdata;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;

    assign accept = bus.req_valid && (state == ST_IDLE);

    // Request in effect: live inputs in IDLE (only matters for LATENCY=0),
    // otherwise the copy latched at acceptance
    always_comb begin
        cur = lat;
        if (state == ST_IDLE) begin
            cur.we    = bus.req_we;
            cur.addr  = bus.req_addr;
            cur.wdata = bus.req_wdata;
        end
    end

    // Flag the edge on which the FSM moves into RESP
    always_comb begin
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: enter_resp = accept && (LATENCY == 0);
            ST_BUSY: enter_resp = (cnt == LAST_CNT);
            default: enter_resp = 1'b0;
        endcase
    end

    assign idx = cur.addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];

`ifdef MEM_ALIGN_CHECK_EN
    logic resp_err_q;
    logic unused_addr_bits;
    assign bad_align        = (cur.addr[BYTE_OFF_W-1:0] != '0);
    assign unused_addr_bits = ^cur.addr[DATA_W-1:ADDR_W+BYTE_OFF_W];
    assign bus.resp_err     = resp_err_q;

    // Error flag rides alongside resp_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= enter_resp && bad_align;
        end
    end
`else
    logic unused_addr_bits;
    assign bad_align        = 1'b0;
    assign unused_addr_bits = ^{cur.addr[DATA_W-1:ADDR_W+BYTE_OFF_W],
                                cur.addr[BYTE_OFF_W-1:0]};
`endif

    assign arr_we = enter_resp && cur.we && !bad_align;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (idx),
        .wdata (cur.wdata),
        .rdata (arr_rdata)
    );

    // FSM, wait counter, request latch and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            lat          <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= enter_resp;
            if (enter_resp && !cur.we && !bad_align) begin
                resp_rdata_q <= arr_rdata;
            end else begin
                resp_rdata_q <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat   <= cur;
                        cnt   <= 4'd0;
                        state <= (LATENCY == 0) ? ST_RESP : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == LAST_CNT) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH_WORDS=256, LATENCY=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LAT = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting in IDLE; checks latency, data and
    // the return to idle. Inputs are scrambled right after acceptance.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int cycles;
        check({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        cycles = 1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        check({tag, " busy"}, {30'd0, dbg_state}, {30'd0, ST_BUSY});
        while (!bus.resp_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, " latency"}, cycles, LAT + 1);
        check({tag, " rdata"}, bus.resp_rdata, exp_rdata);
`ifdef MEM_ALIGN_CHECK_EN
        check({tag, " err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
`else
        if (exp_err) $display("note: %s expects an error flag absent in this build", tag);
`endif
        tick();
        check({tag, " pulse end"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, " rdata clr"}, bus.resp_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int first_e;
        int second_e;
        int seen;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset, then ten idle cycles
        repeat (3) @(posedge clk);
        #1;
        check("in reset state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("in reset valid", {31'd0, bus.resp_valid}, 32'd0);
        #2 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle ready", {31'd0, bus.req_ready}, 32'd1);
            check("idle valid", {31'd0, bus.resp_valid}, 32'd0);
            check("idle rdata", bus.resp_rdata, 32'd0);
        end

        // Basic write then read back
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "wr10");
        do_req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "rd10");

        // Wrap modulo DEPTH_WORDS*4
        do_req(1'b1, 32'h400, 32'h1234, 32'h0, 1'b0, "wr400");
        do_req(1'b0, 32'h000, 32'h0, 32'h1234, 1'b0, "rd000");
        do_req(1'b0, 32'hFFFF_F410, 32'h0, 32'hDEADBEEF, 1'b0, "rd_hi");

        // req_valid held high: one response per accept, period LAT+2
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        pulses = 0; first_e = 0; second_e = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (bus.resp_valid) begin
                pulses++;
                check("held rdata", bus.resp_rdata, 32'hDEADBEEF);
                if (pulses == 1) first_e = e;
                else second_e = e;
            end
            if (e == 4) check("held idle ready", {31'd0, bus.req_ready}, 32'd1);
        end
        bus.req_valid = 1'b0;
        check("held pulses", pulses, 2);
        check("held first", first_e, 3);
        check("held second", second_e, 7);

        // Reset during BUSY of a write: no response, no commit
        do_req(1'b1, 32'h20, 32'h5555AAAA, 32'h0, 1'b0, "wr20");
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFE;
        tick();
        bus.req_valid = 1'b0;
        check("rst busy", {30'd0, dbg_state}, {30'd0, ST_BUSY});
        #2 reset = 1'b1;
        #1;
        check("rst state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rst ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.resp_valid) seen++;
        end
        check("rst no resp", seen, 0);
        do_req(1'b0, 32'h20, 32'h0, 32'h5555AAAA, 1'b0, "rd20 after rst");

        // Misaligned write
`ifdef MEM_ALIGN_CHECK_EN
        do_req(1'b1, 32'h22, 32'h77, 32'h0, 1'b1, "wr22 misal");
        do_req(1'b0, 32'h20, 32'h0, 32'h5555AAAA, 1'b0, "rd20 unchanged");
`else
        do_req(1'b1, 32'h22, 32'h77, 32'h0, 1'b0, "wr22 unal");
        do_req(1'b0, 32'h20, 32'h0, 32'h77, 1'b0, "rd20 updated");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
